// File: rtl/sfp_vec_div_pkg.sv
// ---------------------------------------------------------------------------
// sfp_vec_div_pkg
// Shared definitions for the signed fixed-point vector divider.
//   state_t : control FSM states (IDLE, ITER, FIX, DONE)
//   sfp_k() : number of restoring-division iterations per operation
// ---------------------------------------------------------------------------
package sfp_vec_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The numerator is |a| << FW, which is IW+2*FW bits wide, so one
  // quotient bit is produced per numerator bit.
  function automatic int sfp_k(input int iw, input int fw);
    return iw + 2 * fw;
  endfunction

endpackage

// File: rtl/sfp_vec_div_lane.sv
// ---------------------------------------------------------------------------
// sfp_div_lane
// One lane of the signed fixed-point divider: magnitude/sign capture,
// radix-2 restoring division, and sign/saturation/wrap fix-up.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture a and b (start of an operation)
//   step      : perform one restoring-division iteration
//   fix       : apply sign and overflow handling, register the result
//   a, b      : dividend / divisor, two's complement, IW+FW bits
//   out       : registered quotient, IW+FW bits
//   div_zero  : registered flag, divisor was zero
//   clip      : registered flag, quotient out of range (not set on div_zero)
// ---------------------------------------------------------------------------
module sfp_div_lane
  import sfp_vec_div_pkg::*;
#(
  parameter int IW   = 8,
  parameter int FW   = 8,
  parameter int CLIP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [IW+FW-1:0] a,
  input  logic [IW+FW-1:0] b,
  output logic [IW+FW-1:0] out,
  output logic             div_zero,
  output logic             clip
);

  localparam int W = IW + FW;
  localparam int K = sfp_k(IW, FW);

  // Magnitude limits for the K-bit unsigned quotient: positive results may
  // reach 2^(W-1)-1, negative results may reach 2^(W-1).
  localparam logic [K-1:0] LIM_POS = {{(K-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [K-1:0] LIM_NEG = LIM_POS + K'(1);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // nq holds the numerator in its upper bits and collects quotient bits at
  // the bottom; after K shifts it contains only the quotient magnitude.
  logic [K-1:0] nq;
  logic [W-1:0] den;
  logic [W-1:0] rem;
  logic         sa;
  logic         sb;

  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W:0]   trial;
  logic [W:0]   diff;
  logic         neg;
  logic         dz;
  logic         ovf;
  logic [W-1:0] wrapped;
  logic [W-1:0] result;

  // The most negative input maps to an unsigned magnitude of 2^(W-1),
  // which still fits in W bits.
  assign a_mag = a[W-1] ? (~a + W'(1)) : a;
  assign b_mag = b[W-1] ? (~b + W'(1)) : b;

  // Restoring step: shift the next numerator bit into the partial
  // remainder and subtract the divisor when it fits.
  assign trial = {rem, nq[K-1]};
  assign diff  = trial - {1'b0, den};

  // Fix-up: truncation toward zero falls out of dividing magnitudes and
  // negating afterwards.
  always_comb begin
    neg     = sa ^ sb;
    dz      = (den == '0);
    ovf     = neg ? (nq > LIM_NEG) : (nq > LIM_POS);
    wrapped = neg ? (~nq[W-1:0] + W'(1)) : nq[W-1:0];
    result  = wrapped;
    if (dz) begin
      result = sa ? MIN_NEG : MAX_POS;
    end else if (ovf && (CLIP != 0)) begin
      result = neg ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nq       <= '0;
      den      <= '0;
      rem      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      out      <= '0;
      div_zero <= 1'b0;
      clip     <= 1'b0;
    end else begin
      if (load) begin
        nq  <= {a_mag, {FW{1'b0}}};
        den <= b_mag;
        rem <= '0;
        sa  <= a[W-1];
        sb  <= b[W-1];
      end else if (step) begin
        if (trial >= {1'b0, den}) begin
          rem <= diff[W-1:0];
          nq  <= {nq[K-2:0], 1'b1};
        end else begin
          rem <= trial[W-1:0];
          nq  <= {nq[K-2:0], 1'b0};
        end
      end
      if (fix) begin
        out      <= result;
        div_zero <= dz;
        clip     <= ovf && !dz;
      end
    end
  end

endmodule

// File: rtl/sfp_vec_div.sv
// ---------------------------------------------------------------------------
// sfp_vec_div
// N-lane signed fixed-point divider, out[i] = a[i] / b[i], with a
// valid/ready handshake on both sides. One FSM sequences all lanes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   a, b       : N packed lanes of IW+FW bits (lane i at [i*W +: W])
//   in_valid   : operand set valid
//   in_ready   : block idle, can accept operands
//   out        : N packed quotient lanes
//   out_valid  : out/div_zero/clipping valid, held until out_ready
//   out_ready  : consumer takes the result
//   div_zero   : per-lane zero-divisor flag
//   clipping   : OR of per-lane overflow flags
// ---------------------------------------------------------------------------
module sfp_vec_div
  import sfp_vec_div_pkg::*;
#(
  parameter int IW   = 8,
  parameter int FW   = 8,
  parameter int N    = 3,
  parameter int CLIP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*(IW+FW)-1:0]   a,
  input  logic [N*(IW+FW)-1:0]   b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N*(IW+FW)-1:0]   out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           div_zero,
  output logic                   clipping
);

  localparam int W  = IW + FW;
  localparam int K  = sfp_k(IW, FW);
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] K_CNT = CW'(K);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          accept;
  logic          step;
  logic          fix;
  logic [N-1:0]  lane_clip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ITER spends K cycles iterating plus one cycle recognising the final
  // count, so the result appears K+2 cycles after the accept edge.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ITER;
        end
      end
      ITER: begin
        if (count == K_CNT) begin
          state_next = FIX;
        end else begin
          step = 1'b1;
        end
      end
      FIX: begin
        fix        = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (step) begin
      count <= count + CW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign clipping  = |lane_clip;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sfp_div_lane #(
      .IW   (IW),
      .FW   (FW),
      .CLIP (CLIP)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (step),
      .fix      (fix),
      .a        (a[i*W +: W]),
      .b        (b[i*W +: W]),
      .out      (out[i*W +: W]),
      .div_zero (div_zero[i]),
      .clip     (lane_clip[i])
    );
  end

endmodule

// File: tb/tb_sfp_vec_div.sv
// ---------------------------------------------------------------------------
// tb_sfp_vec_div
// Directed bench for sfp_vec_div at IW=8, FW=8, N=3. A saturating instance
// and a wrapping instance share the stimulus so both overflow modes are
// checked from the same operand sets.
// ---------------------------------------------------------------------------
module tb_sfp_vec_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] a;
  logic [47:0] b;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready;
  logic [47:0] out;
  logic        out_valid;
  logic [2:0]  div_zero;
  logic        clipping;

  logic        in_ready_w;
  logic [47:0] out_w;
  logic        out_valid_w;
  logic [2:0]  div_zero_w;
  logic        clipping_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sfp_vec_div #(.IW(8), .FW(8), .N(3), .CLIP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_zero  (div_zero),
    .clipping  (clipping)
  );

  sfp_vec_div #(.IW(8), .FW(8), .N(3), .CLIP(0)) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .out       (out_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .div_zero  (div_zero_w),
    .clipping  (clipping_w)
  );

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present operands, take the accept edge, scramble the inputs during the
  // operation, and return the cycle count until out_valid.
  task automatic applyStimulus(input logic [47:0] av, input logic [47:0] bv,
                               output int lat);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {47'd0, in_ready}, 48'd1);
    tick();
    in_valid = 1'b0;
    a        = 48'hDEAD_BEEF_1234;
    b        = 48'h0000_0000_0000;
    lat      = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic runCase(input string tag, input logic [47:0] av,
                         input logic [47:0] bv, input logic [47:0] exp_out,
                         input logic [2:0] exp_dz, input logic exp_clip,
                         input logic [47:0] exp_wout, input logic exp_wclip);
    int lat;
    applyStimulus(av, bv, lat);
    $display("[TB] case %s latency=%0d", tag, lat);
    checkOutput({tag, "_latency"}, 48'(lat), 48'd26);
    checkOutput({tag, "_out"}, out, exp_out);
    checkOutput({tag, "_div_zero"}, {45'd0, div_zero}, {45'd0, exp_dz});
    checkOutput({tag, "_clipping"}, {47'd0, clipping}, {47'd0, exp_clip});
    checkOutput({tag, "_wrap_out"}, out_w, exp_wout);
    checkOutput({tag, "_wrap_clipping"}, {47'd0, clipping_w}, {47'd0, exp_wclip});
    checkOutput({tag, "_wrap_valid"}, {47'd0, out_valid_w}, 48'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_idle_after_consume"}, {46'd0, in_ready, out_valid}, 48'b10);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("reset_in_ready", {47'd0, in_ready}, 48'd1);
    checkOutput("reset_out_valid", {47'd0, out_valid}, 48'd0);
    checkOutput("reset_out", out, 48'd0);
    checkOutput("reset_flags", {45'd0, div_zero, clipping}, 48'd0);
    checkOutput("reset_wrap_in_ready", {47'd0, in_ready_w}, 48'd1);

    // 3/2, -1/4, 1/3 (truncated)
    runCase("basic", {16'h0100, 16'hFF00, 16'h0300}, {16'h0300, 16'h0400, 16'h0200},
            {16'h0055, 16'hFFC0, 16'h0180}, 3'b000, 1'b0,
            {16'h0055, 16'hFFC0, 16'h0180}, 1'b0);

    // 3/-2, 0/1, -1/-3
    runCase("signs", {16'h0300, 16'h0000, 16'hFF00}, {16'hFE00, 16'h0100, 16'hFD00},
            {16'hFE80, 16'h0000, 16'h0055}, 3'b000, 1'b0,
            {16'hFE80, 16'h0000, 16'h0055}, 1'b0);

    // 1/1, -128/-1, 100/0.25
    runCase("overflow", {16'h0100, 16'h8000, 16'h6400}, {16'h0100, 16'hFF00, 16'h0040},
            {16'h0100, 16'h7FFF, 16'h7FFF}, 3'b000, 1'b1,
            {16'h0100, 16'h8000, 16'h9000}, 1'b1);

    // Exact range bounds: 0/1, 127.996/1, -64/0.5 = -128
    runCase("bounds", {16'h0000, 16'h7FFF, 16'hC000}, {16'h0100, 16'h0100, 16'h0080},
            {16'h0000, 16'h7FFF, 16'h8000}, 3'b000, 1'b0,
            {16'h0000, 16'h7FFF, 16'h8000}, 1'b0);

    // 1/127.996 -> 0, -1/0.5, -128/(1/256) negative overflow
    runCase("neg_overflow", {16'h0001, 16'hFF00, 16'h8000}, {16'h7FFF, 16'h0080, 16'h0001},
            {16'h0000, 16'hFE00, 16'h8000}, 3'b000, 1'b1,
            {16'h0000, 16'hFE00, 16'h0000}, 1'b1);

    // Zero divisors
    runCase("div_zero", {16'h0000, 16'hFF00, 16'h0100}, 48'd0,
            {16'h7FFF, 16'h8000, 16'h7FFF}, 3'b111, 1'b0,
            {16'h7FFF, 16'h8000, 16'h7FFF}, 1'b0);
    checkOutput("div_zero_wrap_flags", {45'd0, div_zero_w}, 48'b111);

    // Backpressure: result held with out_ready low while inputs toggle
    applyStimulus({16'h0100, 16'hFF00, 16'h0300}, {16'h0300, 16'h0400, 16'h0200}, lat);
    checkOutput("bp_latency", 48'(lat), 48'd26);
    for (int i = 0; i < 10; i++) begin
      a        = 48'(i * 48'h0123_4567);
      b        = 48'(i);
      in_valid = 1'b1;
      checkOutput("bp_out", out, {16'h0055, 16'hFFC0, 16'h0180});
      checkOutput("bp_handshake", {46'd0, in_ready, out_valid}, 48'b01);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_release", {46'd0, in_ready, out_valid}, 48'b10);

    // Reset during ITER discards the operation
    a        = {16'h6400, 16'h8000, 16'h0300};
    b        = {16'h0040, 16'hFF00, 16'h0200};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("mid_iter_busy", {46'd0, in_ready, out_valid}, 48'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_reset_handshake", {46'd0, in_ready, out_valid}, 48'b10);
    checkOutput("mid_reset_out", out, 48'd0);
    checkOutput("mid_reset_flags", {45'd0, div_zero, clipping}, 48'd0);
    tick();
    checkOutput("mid_reset_no_pending", {46'd0, in_ready, out_valid}, 48'b10);

    runCase("after_reset", {16'h0300, 16'h0300, 16'h0300}, {16'h0200, 16'h0200, 16'h0200},
            {16'h0180, 16'h0180, 16'h0180}, 3'b000, 1'b0,
            {16'h0180, 16'h0180, 16'h0180}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
